// File: rtl/brew_pkg.sv
// Shared types for the brew sequencer: state encoding, fault codes and duration width.
package brew_pkg;

   localparam int DUR_W = 16;
   typedef logic [DUR_W-1:0] dur_t;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_PREHEAT = 4'd1,
      ST_PAPER   = 4'd2,
      ST_GRIND   = 4'd3,
      ST_POUR    = 4'd4,
      ST_BLOOM   = 4'd5,
      ST_DIRECT  = 4'd6,
      ST_DONE    = 4'd7,
      ST_FAULT   = 4'd8
   } state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ESTOP   = 3'd1;
   localparam logic [2:0] FC_SYS     = 3'd2;
   localparam logic [2:0] FC_TIMEOUT = 3'd3;
   localparam logic [2:0] FC_FILTER  = 3'd4;
   localparam logic [2:0] FC_WATER   = 3'd5;
   localparam logic [2:0] FC_ABORT   = 3'd6;

   // States in which a brew is in progress and the fault checks apply.
   function automatic logic is_active(state_t s);
      return (s == ST_PREHEAT) || (s == ST_PAPER) || (s == ST_GRIND) ||
             (s == ST_POUR) || (s == ST_BLOOM) || (s == ST_DIRECT);
   endfunction

endpackage

// File: rtl/brew_sequencer_if.sv
// Control, plant-status and actuator signals between a brew controller and brew_sequencer.
interface brew_sequencer_if;
   import brew_pkg::*;

   // start/abort/clear_fault are levels sampled every clk edge; start is accepted only
   // in IDLE and there is no ready: brewing_active/brew_fault report that it is busy.
   logic       start;
   logic       abort;
   logic       clear_fault;
   logic       grinder_sel;
   dur_t       grind_ms;
   dur_t       pour_ms;
   dur_t       direct_ms;

   logic       temp_ready;
   logic       pressure_ready;
   logic       water_system_ok;
   logic       paper_filter_present;
   logic       system_fault;
   logic       emergency_stop;

   logic       heater_cmd;
   logic       paper_motor_cmd;
   logic       grinder0_cmd;
   logic       grinder1_cmd;
   logic       water_pour_cmd;
   logic       water_direct_cmd;
   logic       brewing_active;
   logic       brew_done;
   logic       brew_fault;
   logic [2:0] fault_code;
   logic [3:0] state_code;

   modport slave (
      input  start, abort, clear_fault, grinder_sel, grind_ms, pour_ms, direct_ms,
      input  temp_ready, pressure_ready, water_system_ok, paper_filter_present,
      input  system_fault, emergency_stop,
      output heater_cmd, paper_motor_cmd, grinder0_cmd, grinder1_cmd,
      output water_pour_cmd, water_direct_cmd, brewing_active, brew_done,
      output brew_fault, fault_code, state_code
   );

   modport master (
      output start, abort, clear_fault, grinder_sel, grind_ms, pour_ms, direct_ms,
      output temp_ready, pressure_ready, water_system_ok, paper_filter_present,
      output system_fault, emergency_stop,
      input  heater_cmd, paper_motor_cmd, grinder0_cmd, grinder1_cmd,
      input  water_pour_cmd, water_direct_cmd, brewing_active, brew_done,
      input  brew_fault, fault_code, state_code
   );

endinterface

// File: rtl/ms_tick_gen.sv
// Divides clk by DIV to give a one-cycle millisecond tick; clr restarts the period.
module ms_tick_gen #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt_q <= '0;
      else if (en)
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

endmodule

// File: rtl/brew_sequencer.sv
// Coffee brew sequencer: preheat, paper, grind, pour, direct water, with fault handling.
// Optional bloom pause inside POUR is compiled only when BREW_SEQ_BLOOM_EN is defined.
module brew_sequencer
   import brew_pkg::*;
#(
   parameter int TICK_DIV           = 50000,
   parameter int PREHEAT_TIMEOUT_MS = 30000,
   parameter int PAPER_MS           = 500,
   parameter int BLOOM_MS           = 3000
) (
   input  logic             clk,
   input  logic             rst,
   brew_sequencer_if.slave  bus
);

   state_t     state_q, state_d;
   logic [2:0] fault_q, fault_d;
   dur_t       ms_cnt_q;
   dur_t       dur;
   logic       tick, tick_en, clr, stage_done;
   logic       pause_q;
   logic       grinder_q;
   dur_t       grind_q, pour_q, direct_q;
`ifdef BREW_SEQ_BLOOM_EN
   logic       pour_second_q;
`endif

   // Any state change restarts both the prescaler and the stage counter.
   assign clr     = (state_d != state_q);
   assign tick_en = !((state_q == ST_POUR) && pause_q);

   ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (tick_en),
      .tick (tick)
   );

   always_comb begin
      dur = '0;
      case (state_q)
         ST_PREHEAT: dur = dur_t'(PREHEAT_TIMEOUT_MS);
         ST_PAPER:   dur = dur_t'(PAPER_MS);
         ST_GRIND:   dur = grind_q;
`ifdef BREW_SEQ_BLOOM_EN
         ST_POUR:    dur = pour_second_q ? (pour_q - (pour_q >> 1)) : (pour_q >> 1);
         ST_BLOOM:   dur = dur_t'(BLOOM_MS);
`else
         ST_POUR:    dur = pour_q;
`endif
         ST_DIRECT:  dur = direct_q;
         default:    dur = '0;
      endcase
   end

   // A zero duration still occupies the stage for one cycle.
   assign stage_done = (dur == '0) || (tick && ((ms_cnt_q + dur_t'(1)) == dur));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fault_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      if (is_active(state_q)) begin
         if (bus.emergency_stop) begin
            state_d = ST_FAULT;
            fault_d = FC_ESTOP;
         end else if (bus.system_fault) begin
            state_d = ST_FAULT;
            fault_d = FC_SYS;
         end else if (!bus.water_system_ok && (state_q == ST_POUR || state_q == ST_DIRECT)) begin
            state_d = ST_FAULT;
            fault_d = FC_WATER;
         end else if (bus.abort) begin
            state_d = ST_FAULT;
            fault_d = FC_ABORT;
         end else begin
            case (state_q)
               ST_PREHEAT: begin
                  if (bus.temp_ready && bus.pressure_ready) begin
                     state_d = ST_PAPER;
                  end else if (stage_done) begin
                     state_d = ST_FAULT;
                     fault_d = FC_TIMEOUT;
                  end
               end
               ST_PAPER:  if (stage_done) state_d = ST_GRIND;
               ST_GRIND:  if (stage_done) state_d = ST_POUR;
`ifdef BREW_SEQ_BLOOM_EN
               ST_POUR: begin
                  if (stage_done)
                     state_d = (!pour_second_q && pour_q != '0) ? ST_BLOOM : ST_DIRECT;
               end
               ST_BLOOM:  if (stage_done) state_d = ST_POUR;
`else
               ST_POUR:   if (stage_done) state_d = ST_DIRECT;
`endif
               ST_DIRECT: if (stage_done) state_d = ST_DONE;
               default:   state_d = state_q;
            endcase
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_FAULT;
                  if (!bus.paper_filter_present)
                     fault_d = FC_FILTER;
                  else if (!bus.water_system_ok)
                     fault_d = FC_WATER;
                  else if (bus.system_fault)
                     fault_d = FC_SYS;
                  else
                     state_d = ST_PREHEAT;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAULT: begin
               if (bus.clear_fault && !bus.emergency_stop && !bus.system_fault) begin
                  state_d = ST_IDLE;
                  fault_d = FC_NONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         ms_cnt_q <= '0;
      else if (tick)
         ms_cnt_q <= ms_cnt_q + dur_t'(1);
   end

   // Registered copy of !temp_ready gates both the pour valve and the POUR timer,
   // so valve-open time always equals the programmed pour time.
   always_ff @(posedge clk) begin
      if (rst) begin
         pause_q   <= 1'b0;
         grinder_q <= 1'b0;
         grind_q   <= '0;
         pour_q    <= '0;
         direct_q  <= '0;
      end else begin
         pause_q <= !bus.temp_ready;
         if (state_q == ST_IDLE && bus.start) begin
            grinder_q <= bus.grinder_sel;
            grind_q   <= bus.grind_ms;
            pour_q    <= bus.pour_ms;
            direct_q  <= bus.direct_ms;
         end
      end
   end

`ifdef BREW_SEQ_BLOOM_EN
   always_ff @(posedge clk) begin
      if (rst || state_q == ST_IDLE)
         pour_second_q <= 1'b0;
      else if (state_q == ST_BLOOM)
         pour_second_q <= 1'b1;
   end
`endif

   always_comb begin
      bus.heater_cmd       = is_active(state_q);
      bus.paper_motor_cmd  = (state_q == ST_PAPER);
      bus.grinder0_cmd     = (state_q == ST_GRIND) && !grinder_q;
      bus.grinder1_cmd     = (state_q == ST_GRIND) && grinder_q;
      bus.water_pour_cmd   = (state_q == ST_POUR) && !pause_q;
      bus.water_direct_cmd = (state_q == ST_DIRECT);
      bus.brewing_active   = is_active(state_q);
      bus.brew_done        = (state_q == ST_DONE);
      bus.brew_fault       = (state_q == ST_FAULT);
      bus.fault_code       = fault_q;
      bus.state_code       = state_q;
   end

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer: normal brew, pause, skip, faults, reset, optional bloom.
module tb_brew_sequencer;

   localparam int TICK_DIV = 10;
`ifdef BREW_SEQ_BLOOM_EN
   localparam int BLOOM_CYC = 30;
   localparam int POUR_PRE  = 40;
`else
   localparam int BLOOM_CYC = 0;
   localparam int POUR_PRE  = 80;
`endif

   logic clk = 1'b0;
   logic rst;

   brew_sequencer_if bus ();

   brew_sequencer #(
      .TICK_DIV           (TICK_DIV),
      .PREHEAT_TIMEOUT_MS (20),
      .PAPER_MS           (3),
      .BLOOM_MS           (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int n_paper, n_g0, n_g1, n_pour, n_pour_pre, n_pour_state, n_bloom, n_direct, n_done, n_multi;
   bit finished;

   logic [4:0] cmds;
   assign cmds = {bus.paper_motor_cmd, bus.grinder0_cmd, bus.grinder1_cmd,
                  bus.water_pour_cmd, bus.water_direct_cmd};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_brew();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic clear_fault_pulse();
      bus.clear_fault = 1'b1;
      step();
      bus.clear_fault = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
      int i = 0;
      while (bus.state_code !== s && i < budget) begin
         step();
         i++;
      end
      check_eq(tag, bus.state_code, s);
   endtask

   // Samples one output set per cycle until DONE has been seen and IDLE is back.
   task automatic run_brew(input int pause_at);
      int  pause_left = 0;
      bit  paused = 0;
      bit  seen_done = 0;
      n_paper = 0; n_g0 = 0; n_g1 = 0; n_pour = 0; n_pour_pre = 0; n_pour_state = 0;
      n_bloom = 0; n_direct = 0; n_done = 0; n_multi = 0;
      finished = 0;
      for (int i = 0; i < 2000 && !finished; i++) begin
         n_paper  += int'(bus.paper_motor_cmd);
         n_g0     += int'(bus.grinder0_cmd);
         n_g1     += int'(bus.grinder1_cmd);
         n_pour   += int'(bus.water_pour_cmd);
         n_direct += int'(bus.water_direct_cmd);
         n_done   += int'(bus.brew_done);
         if (bus.water_pour_cmd && n_bloom == 0) n_pour_pre++;
         if (bus.state_code == 4'd4) n_pour_state++;
         if (bus.state_code == 4'd5) n_bloom++;
         if ($countones(cmds) > 1) n_multi++;
         if (bus.brew_done) seen_done = 1;
         if (seen_done && bus.state_code == 4'd0) begin
            finished = 1;
         end else begin
            if (pause_left > 0) begin
               if (pause_left == 25) begin
                  check_eq("pause_pour_low", bus.water_pour_cmd, 1'b0);
                  check_eq("pause_in_pour", bus.state_code, 4'd4);
               end
               pause_left--;
               if (pause_left == 0) bus.temp_ready = 1'b1;
            end else if (!paused && pause_at > 0 && n_pour == pause_at) begin
               bus.temp_ready = 1'b0;
               pause_left = 30;
               paused = 1;
            end
            step();
         end
      end
      check_eq("brew_finished", finished, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_pre;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      bus.clear_fault = 1'b0;
      bus.grinder_sel = 1'b1;
      bus.grind_ms = 16'd5;
      bus.pour_ms = 16'd8;
      bus.direct_ms = 16'd4;
      bus.temp_ready = 1'b1;
      bus.pressure_ready = 1'b1;
      bus.water_system_ok = 1'b1;
      bus.paper_filter_present = 1'b1;
      bus.system_fault = 1'b0;
      bus.emergency_stop = 1'b0;

      // Reset with start held high: must stay IDLE with everything low.
      step();
      step();
      check_eq("rst_state", bus.state_code, 4'd0);
      check_eq("rst_cmds", cmds, 5'd0);
      check_eq("rst_heater", bus.heater_cmd, 1'b0);
      check_eq("rst_fault_code", bus.fault_code, 3'd0);
      check_eq("rst_flags", {bus.brewing_active, bus.brew_done, bus.brew_fault}, 3'd0);
      bus.start = 1'b0;
      rst = 1'b0;
      step();
      check_eq("idle_after_rst", bus.state_code, 4'd0);

      // Normal brew, grinder1; inputs changed after start must be ignored.
      start_brew();
      check_eq("preheat_state", bus.state_code, 4'd1);
      check_eq("preheat_heater", bus.heater_cmd, 1'b1);
      check_eq("preheat_active", bus.brewing_active, 1'b1);
      bus.grind_ms = 16'd9;
      bus.grinder_sel = 1'b0;
      run_brew(-1);
      check_eq("paper_cycles", n_paper, 30);
      check_eq("grinder1_cycles", n_g1, 50);
      check_eq("grinder0_cycles", n_g0, 0);
      check_eq("pour_cycles", n_pour, 80);
      check_eq("pour_before_bloom", n_pour_pre, POUR_PRE);
      check_eq("bloom_cycles", n_bloom, BLOOM_CYC);
      check_eq("direct_cycles", n_direct, 40);
      check_eq("done_pulses", n_done, 1);
      check_eq("one_hot_cmds", n_multi, 0);
      check_eq("end_heater", bus.heater_cmd, 1'b0);
      check_eq("end_active", bus.brewing_active, 1'b0);

      // temp_ready drops for 3 ms in POUR: valve closes, total valve time unchanged.
      bus.grind_ms = 16'd5;
      bus.grinder_sel = 1'b1;
      start_brew();
      run_brew(20);
      check_eq("pause_pour_cycles", n_pour, 80);
      check_eq("pause_grinder1", n_g1, 50);

      // Zero pour: POUR lasts one cycle and BLOOM is never entered.
      bus.grind_ms = 16'd1;
      bus.pour_ms = 16'd0;
      bus.direct_ms = 16'd1;
      start_brew();
      run_brew(-1);
      check_eq("zero_pour_state", n_pour_state, 1);
      check_eq("zero_pour_bloom", n_bloom, 0);
      check_eq("zero_grind1", n_g1, 10);
      check_eq("zero_direct", n_direct, 10);
      bus.grind_ms = 16'd5;
      bus.pour_ms = 16'd8;
      bus.direct_ms = 16'd4;

      // Start without a filter.
      bus.paper_filter_present = 1'b0;
      start_brew();
      check_eq("nofilter_state", bus.state_code, 4'd8);
      check_eq("nofilter_code", bus.fault_code, 3'd4);
      check_eq("nofilter_flag", bus.brew_fault, 1'b1);
      check_eq("nofilter_cmds", {cmds, bus.heater_cmd, bus.brewing_active}, 7'd0);
      clear_fault_pulse();
      check_eq("nofilter_clear_state", bus.state_code, 4'd0);
      check_eq("nofilter_clear_code", bus.fault_code, 3'd0);
      bus.paper_filter_present = 1'b1;

      // Water fault outranks system fault at start; clear blocked while system_fault=1.
      bus.water_system_ok = 1'b0;
      bus.system_fault = 1'b1;
      start_brew();
      check_eq("start_water_code", bus.fault_code, 3'd5);
      bus.water_system_ok = 1'b1;
      clear_fault_pulse();
      check_eq("clear_blocked_sys", bus.state_code, 4'd8);
      start_brew();
      check_eq("start_in_fault_ignored", bus.fault_code, 3'd5);
      bus.system_fault = 1'b0;
      clear_fault_pulse();
      check_eq("clear_after_sys", bus.state_code, 4'd0);

      // Preheat timeout: 20 ms of 10 cycles.
      bus.temp_ready = 1'b0;
      start_brew();
      n_pre = 0;
      while (bus.state_code == 4'd1 && n_pre < 400) begin
         n_pre++;
         step();
      end
      check_eq("timeout_cycles", n_pre, 200);
      check_eq("timeout_state", bus.state_code, 4'd8);
      check_eq("timeout_code", bus.fault_code, 3'd3);
      check_eq("timeout_heater", bus.heater_cmd, 1'b0);
      bus.temp_ready = 1'b1;
      clear_fault_pulse();
      check_eq("timeout_clear", bus.state_code, 4'd0);

      // Emergency stop in GRIND.
      start_brew();
      wait_state(4'd3, 200, "reach_grind");
      repeat (5) step();
      bus.emergency_stop = 1'b1;
      step();
      check_eq("estop_state", bus.state_code, 4'd8);
      check_eq("estop_code", bus.fault_code, 3'd1);
      check_eq("estop_cmds", {cmds, bus.heater_cmd}, 6'd0);
      bus.clear_fault = 1'b1;
      step();
      check_eq("estop_clear_blocked", bus.state_code, 4'd8);
      bus.emergency_stop = 1'b0;
      step();
      bus.clear_fault = 1'b0;
      check_eq("estop_cleared", bus.state_code, 4'd0);
      check_eq("estop_code_cleared", bus.fault_code, 3'd0);

      // Reset in the middle of POUR.
      start_brew();
      wait_state(4'd4, 300, "reach_pour");
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_state", bus.state_code, 4'd0);
      check_eq("midrst_outs", {cmds, bus.heater_cmd, bus.brewing_active, bus.brew_fault}, 8'd0);

      // Abort in PAPER.
      start_brew();
      wait_state(4'd2, 50, "reach_paper");
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_eq("abort_code", bus.fault_code, 3'd6);
      check_eq("abort_cmds", cmds, 5'd0);
      clear_fault_pulse();

      // Water loss in DIRECT.
      start_brew();
      wait_state(4'd6, 400, "reach_direct");
      bus.water_system_ok = 1'b0;
      step();
      check_eq("water_direct_code", bus.fault_code, 3'd5);
      check_eq("water_direct_cmd", bus.water_direct_cmd, 1'b0);
      bus.water_system_ok = 1'b1;
      clear_fault_pulse();
      check_eq("final_idle", bus.state_code, 4'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
